// File: rtl/jac1_pkg.sv
// Shared JAC1 types and defaults for the register-value trace path.
package jac1_pkg;

   localparam int unsigned DefDataWidth = 8;
   localparam int unsigned DefTsWidth   = 16;

   typedef logic [DefDataWidth-1:0] reg_val_t;
   typedef logic [DefTsWidth-1:0]   trace_ts_t;

   typedef struct packed {
      trace_ts_t ts;
      reg_val_t  value;
   } trace_rec_t;

endpackage

// File: rtl/jac1_trace_fifo.sv
// Generic synchronous show-ahead FIFO; full/empty are derived from the occupancy count.
module jac1_trace_fifo #(
   parameter int unsigned Width = 24,
   parameter int unsigned Depth = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic [Width-1:0]         wdata,
   output logic [Width-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(Depth):0]   count
);

   localparam int unsigned AddrW = $clog2(Depth);
   localparam int unsigned CntW  = AddrW + 1;

   logic [Width-1:0] mem_q [Depth];
   logic [AddrW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0]  count_q, count_d;
   logic             do_push, do_pop;

   assign empty = (count_q == '0);
   assign full  = (count_q == CntW'(Depth));

   // A pop frees the slot the same cycle, so a full FIFO still accepts a push.
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   always_comb begin
      count_d = count_q;
      if (do_push && !do_pop) begin
         count_d = count_q + CntW'(1);
      end else if (do_pop && !do_push) begin
         count_d = count_q - CntW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(Depth); i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
            wr_ptr_q        <= wr_ptr_q + AddrW'(1);
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + AddrW'(1);
         end
         count_q <= count_d;
      end
   end

   assign rdata = mem_q[rd_ptr_q];
   assign count = count_q;

endmodule

// File: rtl/jac1_reg_tracer.sv
// Trace monitor for JAC1 reg_val: timestamps value changes (or every cycle) into a FIFO
// drained over a valid/ready port.
module jac1_reg_tracer
   import jac1_pkg::*;
#(
   parameter int unsigned DataWidth = DefDataWidth,
   parameter int unsigned TsWidth   = DefTsWidth,
   parameter int unsigned Depth     = 8
) (
   input  logic                   clk,
   input  logic                   sys_res_n,
   input  logic [DataWidth-1:0]   reg_val,
   input  logic                   trace_en,
   input  logic                   mode_all,
   input  logic                   clr_ovf,
   input  logic                   rd_ready,
   output logic                   rd_valid,
   output logic [DataWidth-1:0]   rd_value,
   output logic [TsWidth-1:0]     rd_time,
   output logic [$clog2(Depth):0] count,
   output logic                   overflow
);

   localparam int unsigned RecW = TsWidth + DataWidth;

   logic [TsWidth-1:0]   ts_q;
   logic [DataWidth-1:0] prev_q;
   logic                 ovf_q, ovf_d;
   logic                 chg, cap, drop;
   logic                 fifo_full, fifo_empty;
   logic [RecW-1:0]      rec_wdata, rec_rdata;

   assign chg       = (reg_val != prev_q);
   assign cap       = trace_en & (mode_all | chg);
   // Full implies non-empty, so rd_ready alone means a pop is happening.
   assign drop      = cap & fifo_full & ~rd_ready;
   assign rec_wdata = {ts_q, reg_val};

   always_comb begin
      ovf_d = ovf_q;
      if (drop) begin
         ovf_d = 1'b1;
      end else if (clr_ovf) begin
         ovf_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge sys_res_n) begin
      if (!sys_res_n) begin
         ts_q   <= '0;
         prev_q <= '0;
         ovf_q  <= 1'b0;
      end else begin
         if (trace_en) begin
            ts_q   <= ts_q + TsWidth'(1);
            prev_q <= reg_val;
         end
         ovf_q <= ovf_d;
      end
   end

   jac1_trace_fifo #(
      .Width (RecW),
      .Depth (Depth)
   ) u_fifo (
      .clk   (clk),
      .rst_n (sys_res_n),
      .push  (cap),
      .pop   (rd_ready),
      .wdata (rec_wdata),
      .rdata (rec_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (count)
   );

   assign rd_valid = ~fifo_empty;
   assign rd_value = rec_rdata[DataWidth-1:0];
   assign rd_time  = rec_rdata[RecW-1:DataWidth];
   assign overflow = ovf_q;

endmodule

// File: tb/tb_jac1_reg_tracer.sv
// Bench for jac1_reg_tracer: directed scenarios plus random traffic against a queue model.
module tb_jac1_reg_tracer;

   logic       clk = 1'b0;
   logic       sys_res_n = 1'b0;
   logic [7:0] reg_val = '0;
   logic       trace_en = 1'b0, mode_all = 1'b0, clr_ovf = 1'b0, rd_ready = 1'b0;
   logic       rd_valid, overflow;
   logic [7:0] rd_value;
   logic [15:0] rd_time;
   logic [3:0] count;

   logic [7:0] reg_val4 = '0;
   logic       en4 = 1'b0, mode4 = 1'b0, rd4 = 1'b0;
   logic       rd_valid4, overflow4;
   logic [7:0] rd_value4;
   logic [3:0] rd_time4;
   logic [3:0] count4;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   jac1_reg_tracer u_dut (
      .clk (clk), .sys_res_n (sys_res_n), .reg_val (reg_val), .trace_en (trace_en),
      .mode_all (mode_all), .clr_ovf (clr_ovf), .rd_ready (rd_ready), .rd_valid (rd_valid),
      .rd_value (rd_value), .rd_time (rd_time), .count (count), .overflow (overflow)
   );

   jac1_reg_tracer #(.TsWidth (4)) u_dut4 (
      .clk (clk), .sys_res_n (sys_res_n), .reg_val (reg_val4), .trace_en (en4),
      .mode_all (mode4), .clr_ovf (1'b0), .rd_ready (rd4), .rd_valid (rd_valid4),
      .rd_value (rd_value4), .rd_time (rd_time4), .count (count4), .overflow (overflow4)
   );

   // Reference model: a queue of {time, value} records and plain integer state.
   typedef struct {int t; int v;} rec_t;
   rec_t m_q[$];
   int   m_ts, m_prev;
   bit   m_ovf;

   task automatic model_reset();
      m_q.delete();
      m_ts = 0;
      m_prev = 0;
      m_ovf = 0;
   endtask

   task automatic model_step();
      bit pop, cap, dropped;
      pop = (m_q.size() > 0) && rd_ready;
      cap = trace_en && (mode_all || int'(reg_val) != m_prev);
      dropped = 0;
      if (pop) m_q.delete(0);
      if (cap) begin
         if (m_q.size() < 8) m_q.push_back('{m_ts, int'(reg_val)});
         else dropped = 1;
      end
      if (dropped) m_ovf = 1;
      else if (clr_ovf) m_ovf = 0;
      if (trace_en) begin
         m_ts = (m_ts + 1) % 65536;
         m_prev = int'(reg_val);
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_model(input string tag);
      chk({tag, "_valid"}, 32'(rd_valid), 32'(m_q.size() != 0));
      chk({tag, "_count"}, 32'(count), 32'(m_q.size()));
      chk({tag, "_ovf"}, 32'(overflow), 32'(m_ovf));
      if (m_q.size() != 0) begin
         chk({tag, "_value"}, 32'(rd_value), 32'(m_q[0].v));
         chk({tag, "_time"}, 32'(rd_time), 32'(m_q[0].t));
      end
   endtask

   // Called at a negedge with inputs set; advances one edge and checks at the next negedge.
   task automatic cycle(input string tag);
      model_step();
      @(posedge clk);
      @(negedge clk);
      check_model(tag);
   endtask

   task automatic do_reset();
      @(negedge clk);
      trace_en = 0; mode_all = 0; clr_ovf = 0; rd_ready = 0; reg_val = 0;
      sys_res_n = 0;
      model_reset();
      #1;
      chk("rst_valid", 32'(rd_valid), 0);
      chk("rst_count", 32'(count), 0);
      chk("rst_ovf", 32'(overflow), 0);
      chk("rst_value", 32'(rd_value), 0);
      chk("rst_time", 32'(rd_time), 0);
      @(negedge clk);
      sys_res_n = 1;
   endtask

   initial begin
      int vals[5];
      vals = '{0, 0, 5, 5, 9};
      model_reset();

      // Reset then change-only capture
      do_reset();
      trace_en = 1; mode_all = 0;
      for (int i = 0; i < 5; i++) begin
         reg_val = 8'(vals[i]);
         cycle("chg");
      end
      chk("chg_count", 32'(count), 2);
      chk("chg_head_time", 32'(rd_time), 2);
      chk("chg_head_value", 32'(rd_value), 5);
      trace_en = 0; rd_ready = 1;
      cycle("chg_pop");
      chk("chg_second_time", 32'(rd_time), 4);
      chk("chg_second_value", 32'(rd_value), 9);
      cycle("chg_pop2");
      chk("chg_drained_valid", 32'(rd_valid), 0);
      cycle("empty_pop");
      chk("empty_count", 32'(count), 0);

      // Every-cycle mode
      do_reset();
      trace_en = 1; mode_all = 1; reg_val = 3;
      for (int i = 0; i < 5; i++) cycle("all");
      chk("all_count", 32'(count), 5);
      chk("all_head_time", 32'(rd_time), 0);

      // Fill and overflow
      do_reset();
      trace_en = 1; mode_all = 0;
      for (int i = 1; i <= 10; i++) begin
         reg_val = 8'(i);
         cycle("fill");
      end
      chk("fill_count", 32'(count), 8);
      chk("fill_ovf", 32'(overflow), 1);
      chk("fill_head_value", 32'(rd_value), 1);
      trace_en = 0; clr_ovf = 1;
      cycle("clr");
      chk("clr_ovf", 32'(overflow), 0);
      clr_ovf = 0;

      // Full with simultaneous read and capture
      trace_en = 1; rd_ready = 1; reg_val = 99;
      cycle("fullrw");
      chk("fullrw_count", 32'(count), 8);
      chk("fullrw_ovf", 32'(overflow), 0);
      chk("fullrw_head_value", 32'(rd_value), 2);

      // Async reset mid-stream
      do_reset();
      trace_en = 1;
      for (int i = 1; i <= 3; i++) begin
         reg_val = 8'(i);
         cycle("pre_ar");
      end
      chk("pre_ar_count", 32'(count), 3);
      trace_en = 0;
      #2 sys_res_n = 0;
      model_reset();
      #1;
      chk("ar_valid", 32'(rd_valid), 0);
      chk("ar_count", 32'(count), 0);
      chk("ar_ovf", 32'(overflow), 0);
      @(negedge clk);
      sys_res_n = 1;
      trace_en = 1; reg_val = 7;
      cycle("post_ar");
      chk("post_ar_time", 32'(rd_time), 0);
      chk("post_ar_value", 32'(rd_value), 7);

      // Random traffic
      do_reset();
      for (int i = 0; i < 400; i++) begin
         trace_en = ($urandom_range(0, 3) != 0);
         mode_all = ($urandom_range(0, 4) == 0);
         clr_ovf  = ($urandom_range(0, 9) == 0);
         rd_ready = ($urandom_range(0, 2) == 0);
         reg_val  = 8'($urandom_range(0, 3));
         cycle("rand");
      end

      // Timestamp wrap on the 4-bit-timestamp instance, drained continuously
      do_reset();
      en4 = 1; mode4 = 1; rd4 = 1;
      for (int k = 1; k <= 18; k++) begin
         cycle("wrap_main");
         chk("wrap_valid", 32'(rd_valid4), 1);
         chk("wrap_time", 32'(rd_time4), 32'((k - 1) % 16));
         chk("wrap_count", 32'(count4), 1);
      end
      en4 = 0; rd4 = 0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/jac1_reg_tracer.md
# jac1_reg_tracer

Parametrised on-chip trace monitor for the JAC1 core. It sits beside `JAC1_Top` and watches its `reg_val` output. It captures each value change, or optionally every cycle, as a {timestamp, value} record in an internal FIFO. A host or bench drains the records over a valid/ready read port. It replaces open-loop waveform inspection of `reg_val` with a self-contained, width- and depth-generic capture path.

## Interface
- `DataWidth`, default 8: width of the watched register value.
- `TsWidth`, default 16: width of the free-running timestamp.
- `Depth`, default 8: FIFO entries; must be a power of two and ≥ 2.
- `clk`  in  1: single clock, all logic on the rising edge.
- `sys_res_n`  in  1: reset, asynchronous and active-low.
- `reg_val`  in  DataWidth: watched value from `JAC1_Top`.
- `trace_en`  in  1: capture and timestamp enable.
- `mode_all`  in  1: 0 captures on change only; 1 captures every enabled cycle.
- `clr_ovf`  in  1: synchronous clear of `overflow`.
- `rd_ready`  in  1: consumer accepts the head record.
- `rd_valid`  out  1: FIFO non-empty.
- `rd_value`  out  DataWidth: head record value.
- `rd_time`  out  TsWidth: head record timestamp.
- `count`  out  $clog2(Depth)+1: current occupancy.
- `overflow`  out  1: sticky flag meaning at least one record was dropped.

## Operation
- **Reset values:**
  - `rd_valid`=0, `count`=0, `overflow`=0.
  - `rd_value`=0, `rd_time`=0, with all memory entries zeroed.
  - Timestamp=0, previous-value register=0, both pointers=0.
- **Timestamp:** increments by 1 on each edge where `trace_en`=1 and holds otherwise. It wraps modulo 2^TsWidth from all-ones to 0 with no flag.
- **Previous value:** `prev` loads `reg_val` on every edge where `trace_en`=1.
- **Change detect:** `chg` = (`reg_val` != `prev`).
  - The first enabled cycle after reset compares against 0.
- **Capture request:** `cap` = `trace_en` & (`mode_all` | `chg`). The stored record is {current timestamp before its increment, `reg_val`}.
- **Read:** a pop occurs when `rd_valid` & `rd_ready`. Outputs are show-ahead: `rd_value` and `rd_time` always present the head entry.
- **Full:** when `count`=Depth, a `cap` with no simultaneous pop is dropped and `overflow` is set.
  - When `cap` and a pop coincide while full, the write is accepted and `count` stays at Depth.
- **Empty:** a `rd_ready` while empty has no effect. `count` never underflows.
- **Simultaneous push and pop while non-empty:** `count` is unchanged and both pointers advance.
- **Pointer wrap:** pointers are log2(Depth) bits and wrap naturally. Full and empty are distinguished via `count`.
- **`overflow`:**
  - Set has priority over `clr_ovf` in the same cycle.
  - Once set, it stays set until a `clr_ovf` cycle with no drop.
- **Reset mid-operation:** asserting `sys_res_n`=0 immediately returns every output to its reset value. All queued records are lost.

## Timing
- A capture at edge N makes `rd_valid`=1 and the record visible in the cycle after edge N. Capture-to-output latency is 1 cycle.
- A pop at edge N exposes the next entry, or drops `rd_valid`, right after edge N.
- Sustained throughput is one capture and one pop per cycle.
- `rd_*` are combinational from the memory and pointer registers. There is no path from `rd_ready` to `rd_valid`.
- Reset deassertion is synchronised externally. The block needs no internal synchroniser.

## Structure
- Shared package `jac1_pkg` holds:
  - `DataWidth` default and the JAC1 register-value type.
  - `TsWidth` default.
  - The trace-record struct {time, value}.
- Sub-module `jac1_trace_fifo` is a generic synchronous FIFO with push, pop, full, empty and count, parametrised on record width and Depth.
- The top level holds the timestamp counter, `prev` register, capture logic and overflow flag.

## Test plan
- **Reset then change:** reset, then `trace_en`=1, `mode_all`=0, `reg_val` sequence 0,0,5,5,9 one per cycle.
  - Expect exactly 2 records: {2,5} and {4,9}.
  - Expect `count`=2 and `overflow`=0.
- **Every-cycle mode:** `mode_all`=1, Depth=8, 5 cycles of constant 3, `rd_ready`=0.
  - Expect records {0..4, 3} and `count`=5.
- **Fill and overflow:** 10 distinct values with `rd_ready`=0.
  - Expect 8 records, the first 8 values retained, `count`=8 and `overflow`=1.
  - Then `clr_ovf` for one cycle: expect `overflow`=0.
- **Full with simultaneous read:** FIFO full, `rd_ready`=1 and a new change in the same cycle.
  - Expect the oldest record popped, the new record accepted, `count`=8 and no overflow.
- **Timestamp wrap:** `TsWidth`=4, `mode_all`=1, 18 enabled cycles drained continuously.
  - Expect times 0..15, 0, 1 in order.
- **Async reset mid-stream:** with `count`=3, drop `sys_res_n` between edges.
  - Expect `rd_valid`=0, `count`=0 and `overflow`=0 before the next edge.
  - After release, the first change record carries timestamp 0.
